key_debounce_onehot_4ch: RTL



---
 rtl/enc_pkg.sv | 21 ++
 rtl/debounce_1ch.sv | 45 ++++
 rtl/key_debounce_onehot_4ch.sv | 100 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the debounced one-hot key front end.
// Latency: none (types and constants only).
// Backpressure: none.
package enc_pkg;

    localparam int NUM_KEYS = 4;
    localparam int SEL_W    = $clog2(NUM_KEYS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NUM_KEYS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/debounce_1ch.sv
// One button: 2-flop synchroniser, then a level that flips only after DEBOUNCE_CYCLES disagreeing samples.
// Latency: stable follows a clean raw change after 2+DEBOUNCE_CYCLES edges.
// Backpressure: none; free-running sampler.
module debounce_1ch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    assign sync = sync_ff[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], btn_raw};
        end
    end

    // Any sample agreeing with the current level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_debounce_onehot_4ch.sv
// Debounces four buttons and grants one of them as a registered one-hot request with enable.
// Latency: grant 3+DEBOUNCE_CYCLES edges after a clean raw press; release alike.
// Backpressure: none; a granted key holds until released, others are ignored meanwhile.
module key_debounce_onehot_4ch
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] btn_raw,
    output logic [NUM_KEYS-1:0] i,
    output logic                en,
    output logic                key_evt
);

    logic [NUM_KEYS-1:0] stable;
    logic                pick_vld;
    logic [SEL_W-1:0]    pick;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    sel, sel_nxt;
    logic [NUM_KEYS-1:0] i_nxt;
    logic                en_nxt;
    logic                evt_nxt;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_db
        debounce_1ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[k]),
            .stable (stable[k])
        );
    end

    // Ascending scan so the highest set index wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (stable[k]) begin
                pick_vld = 1'b1;
                pick     = SEL_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= '0;
            i       <= '0;
            en      <= 1'b0;
            key_evt <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            i       <= i_nxt;
            en      <= en_nxt;
            key_evt <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_vld)     state_nxt = ST_HOLD;
            ST_HOLD: if (!stable[sel]) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Release lands in IDLE with en low, so a waiting key is granted one cycle later.
    always_comb begin
        sel_nxt = sel;
        i_nxt   = '0;
        en_nxt  = 1'b0;
        evt_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    sel_nxt = pick;
                    i_nxt   = onehot(pick);
                    en_nxt  = 1'b1;
                    evt_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (stable[sel]) begin
                    i_nxt  = i;
                    en_nxt = en;
                end
            end
            default: ;
        endcase
    end

endmodule
